// File: rtl/regf_write_arbiter.sv
// regf_write_arbiter: owns the single register-file write port behind WriteBack.
// The pipeline WB write has priority. Debug writes (register preload) queue in a
// small FIFO. A starvation counter forces one stall slot so debug writes always drain.
// Optional feature: define REGF_ARB_STATS_EN to add outForceCnt, a saturating count
// of FORCE cycles.
module regf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inWB_wr,
  input  logic [4:0]       inWB_wa,
  input  logic [31:0]      inWB_wd,
  input  logic             inDbg_valid,
  input  logic [4:0]       inDbg_wa,
  input  logic [31:0]      inDbg_wd,
  output logic             outDbg_ready,
  output logic             outStall,
  output logic             outRegF_wr,
  output logic [4:0]       outRegF_wa,
  output logic [31:0]      outRegF_wd,
  output logic             outGrantDbg,
`ifdef REGF_ARB_STATS_EN
  output logic [15:0]      outForceCnt,
`endif
  output logic [PTR_W:0]   outPending
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [PTR_W:0]   FULL_CT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arbState_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } dbgEntry_t;

  arbState_t         state, stateNext;
  dbgEntry_t         fifoMem [DEPTH];
  dbgEntry_t         head;
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [PTR_W:0]    count, countNext;
  logic [CNT_W-1:0]  starveCnt, starveNext;
  logic              push, pop, wbTake;
  logic              selWr;
  logic [4:0]        selWa;
  logic [31:0]       selWd;

  // Status outputs come straight from registered state.
  assign outDbg_ready = (count != FULL_CT);
  assign outStall     = (state == FORCE);
  assign outPending   = count;
  assign head         = fifoMem[rdPtr];

  // Arbitration: next state, starvation count, FIFO push/pop and port selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    push       = inDbg_valid & outDbg_ready;
    pop        = 1'b0;
    wbTake     = 1'b0;
    starveNext = starveCnt;
    stateNext  = state;

    unique case (state)
      IDLE: begin
        wbTake = inWB_wr;
      end
      PEND: begin
        if (inWB_wr) begin
          wbTake     = 1'b1;
          starveNext = starveCnt + CNT_W'(1);
        end else begin
          pop        = 1'b1;
          starveNext = '0;
        end
      end
      FORCE: begin
        // The pipeline is frozen and re-presents its write next cycle.
        pop        = 1'b1;
        starveNext = '0;
      end
      default: begin
        starveNext = '0;
      end
    endcase

    countNext = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    unique case (state)
      IDLE:    stateNext = push ? PEND : IDLE;
      PEND: begin
        if (countNext == '0)          stateNext = IDLE;
        else if (starveNext == LIMIT) stateNext = FORCE;
        else                          stateNext = PEND;
      end
      FORCE:   stateNext = (countNext != '0) ? PEND : IDLE;
      default: stateNext = IDLE;
    endcase

    selWr = pop | wbTake;
    selWa = pop ? head.wa : inWB_wa;
    selWd = pop ? head.wd : inWB_wd;
  end

  // State, FIFO bookkeeping and the registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      starveCnt   <= '0;
      outRegF_wr  <= 1'b0;
      outRegF_wa  <= '0;
      outRegF_wd  <= '0;
      outGrantDbg <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state       <= stateNext;
      count       <= countNext;
      starveCnt   <= starveNext;
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      // r0 is hardwired to zero, so a write there never reaches the file.
      outRegF_wr  <= selWr && (selWa != 5'd0);
      outRegF_wa  <= selWa;
      outRegF_wd  <= selWd;
      outGrantDbg <= pop;
    end
  end

  // FIFO storage: write the entry at the tail on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset. Validity is tracked by
    // count/pointers, and a reset on the array would turn RAM into flops.
    if (push) fifoMem[wrPtr] <= '{wa: inDbg_wa, wd: inDbg_wd};
  end

`ifdef REGF_ARB_STATS_EN
  logic [15:0] forceCnt;

  // Saturating count of forced debug slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     forceCnt <= '0;
    else if (state == FORCE && forceCnt != 16'hFFFF) forceCnt <= forceCnt + 16'd1;
  end

  assign outForceCnt = forceCnt;
`endif

endmodule

// File: tb/tb_regf_write_arbiter.sv
// Self-checking bench for regf_write_arbiter. It uses a table of single-cycle
// vectors plus hand-written starvation and reset-in-FORCE sequences.
module tb_regf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inWB_wr;
  logic [4:0]  inWB_wa;
  logic [31:0] inWB_wd;
  logic        inDbg_valid;
  logic [4:0]  inDbg_wa;
  logic [31:0] inDbg_wd;
  logic        outDbg_ready;
  logic        outStall;
  logic        outRegF_wr;
  logic [4:0]  outRegF_wa;
  logic [31:0] outRegF_wd;
  logic        outGrantDbg;
  logic [2:0]  outPending;
`ifdef REGF_ARB_STATS_EN
  logic [15:0] outForceCnt;
`endif

  int checks   = 0;
  int failures = 0;

  regf_write_arbiter #(.DEPTH(4), .PTR_W(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .inWB_wr(inWB_wr), .inWB_wa(inWB_wa), .inWB_wd(inWB_wd),
    .inDbg_valid(inDbg_valid), .inDbg_wa(inDbg_wa), .inDbg_wd(inDbg_wd),
    .outDbg_ready(outDbg_ready), .outStall(outStall),
    .outRegF_wr(outRegF_wr), .outRegF_wa(outRegF_wa), .outRegF_wd(outRegF_wd),
    .outGrantDbg(outGrantDbg),
`ifdef REGF_ARB_STATS_EN
    .outForceCnt(outForceCnt),
`endif
    .outPending(outPending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wbWr;
    logic [4:0]  wbWa;
    logic [31:0] wbWd;
    logic        dbgValid;
    logic [4:0]  dbgWa;
    logic [31:0] dbgWd;
    logic        expWr;
    logic [4:0]  expWa;
    logic [31:0] expWd;
    logic        expGrant;
    logic        expStall;
    logic        expReady;
    logic [2:0]  expPending;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic dv, input logic [4:0] dwa, input logic [31:0] dwd);
    inWB_wr = wr; inWB_wa = wa; inWB_wd = wd;
    inDbg_valid = dv; inDbg_wa = dwa; inDbg_wd = dwd;
  endtask

  // Let the DUT take one rising edge and then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                              input logic dv, input logic [4:0] dwa, input logic [31:0] dwd,
                              input logic ew, input logic [4:0] ewa, input logic [31:0] ewd,
                              input logic eg, input logic es, input logic er, input logic [2:0] ep);
    vec_t v;
    v.wbWr = wr; v.wbWa = wa; v.wbWd = wd;
    v.dbgValid = dv; v.dbgWa = dwa; v.dbgWd = dwd;
    v.expWr = ew; v.expWa = ewa; v.expWd = ewd;
    v.expGrant = eg; v.expStall = es; v.expReady = er; v.expPending = ep;
    return v;
  endfunction

  task automatic checkRow(input string tag, input vec_t v);
    check({tag, " wr"},      32'(outRegF_wr),   32'(v.expWr));
    check({tag, " wa"},      32'(outRegF_wa),   32'(v.expWa));
    check({tag, " wd"},      outRegF_wd,        v.expWd);
    check({tag, " grant"},   32'(outGrantDbg),  32'(v.expGrant));
    check({tag, " stall"},   32'(outStall),     32'(v.expStall));
    check({tag, " ready"},   32'(outDbg_ready), 32'(v.expReady));
    check({tag, " pending"}, 32'(outPending),   32'(v.expPending));
  endtask

  initial begin
    bit sawStall;

    //            WB wr wa  wd            dbg v wa  wd        | wr wa  wd           g  s  rdy pend
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,         1, 5,  32'hDEADBEEF, 0, 0, 1, 0); // WB only
    vecs[1]  = mk(0, 0,  0,            1, 3,  32'h12,    0, 0,  0,            0, 0, 1, 1); // push, idle pipe
    vecs[2]  = mk(0, 0,  0,            0, 0,  0,         1, 3,  32'h12,       1, 0, 1, 0); // popped to port
    vecs[3]  = mk(1, 0,  32'hAAAA0000, 1, 0,  32'h55,    0, 0,  32'hAAAA0000, 0, 0, 1, 1); // WB to r0 + dbg r0
    vecs[4]  = mk(0, 0,  0,            0, 0,  0,         0, 0,  32'h55,       1, 0, 1, 0); // r0 debug drains
    vecs[5]  = mk(1, 1,  1,            1, 10, 32'hA0,    1, 1,  1,            0, 0, 1, 1); // fill under WB
    vecs[6]  = mk(1, 2,  2,            1, 11, 32'hA1,    1, 2,  2,            0, 0, 1, 2);
    vecs[7]  = mk(1, 3,  3,            1, 12, 32'hA2,    1, 3,  3,            0, 0, 1, 3);
    vecs[8]  = mk(1, 4,  4,            1, 13, 32'hA3,    1, 4,  4,            0, 0, 0, 4); // full
    vecs[9]  = mk(1, 5,  5,            1, 14, 32'hA4,    1, 5,  5,            0, 0, 0, 4); // 5th dropped
    vecs[10] = mk(0, 0,  0,            1, 15, 32'hA5,    1, 10, 32'hA0,       1, 0, 1, 3); // pop, push not ready
    vecs[11] = mk(0, 0,  0,            1, 16, 32'hA6,    1, 11, 32'hA1,       1, 0, 1, 3); // push+pop
    vecs[12] = mk(0, 0,  0,            0, 0,  0,         1, 12, 32'hA2,       1, 0, 1, 2);
    vecs[13] = mk(0, 0,  0,            0, 0,  0,         1, 13, 32'hA3,       1, 0, 1, 1);
    vecs[14] = mk(0, 0,  0,            0, 0,  0,         1, 16, 32'hA6,       1, 0, 1, 0); // A4/A5 never queued
    vecs[15] = mk(0, 0,  0,            0, 0,  0,         0, 0,  0,            0, 0, 1, 0);

    // Reset state.
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset wr",      32'(outRegF_wr),   0);
    check("reset wa",      32'(outRegF_wa),   0);
    check("reset wd",      outRegF_wd,        0);
    check("reset grant",   32'(outGrantDbg),  0);
    check("reset stall",   32'(outStall),     0);
    check("reset ready",   32'(outDbg_ready), 1);
    check("reset pending", 32'(outPending),   0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wbWr, vecs[i].wbWa, vecs[i].wbWd,
            vecs[i].dbgValid, vecs[i].dbgWa, vecs[i].dbgWd);
      step();
      checkRow($sformatf("vec%0d", i), vecs[i]);
    end

    // Starvation: one queued entry under continuous WB leads to exactly one forced slot after 8 WB wins.
    drive(1, 7, 32'h700, 1, 9, 32'h99);
    step();
    check("starve push pending", 32'(outPending), 1);
    check("starve push stall",   32'(outStall),   0);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 7, 32'h700 + 32'(i), 0, 0, 0);
      step();
      check($sformatf("starve win%0d wd", i),    outRegF_wd,       32'h700 + 32'(i));
      check($sformatf("starve win%0d grant", i), 32'(outGrantDbg), 0);
      check($sformatf("starve win%0d stall", i), 32'(outStall),    (i == 8) ? 1 : 0);
    end
    drive(1, 7, 32'hBAD, 0, 0, 0);  // ignored while stalled
    step();
    check("force slot wr",      32'(outRegF_wr),  1);
    check("force slot wa",      32'(outRegF_wa),  9);
    check("force slot wd",      outRegF_wd,       32'h99);
    check("force slot grant",   32'(outGrantDbg), 1);
    check("force slot stall",   32'(outStall),    0);
    check("force slot pending", 32'(outPending),  0);
`ifdef REGF_ARB_STATS_EN
    check("force count", 32'(outForceCnt), 1);
`endif
    drive(1, 7, 32'h7FF, 0, 0, 0);
    step();
    check("wb resume wa",    32'(outRegF_wa),  7);
    check("wb resume wd",    outRegF_wd,       32'h7FF);
    check("wb resume grant", 32'(outGrantDbg), 0);

    // Async reset while in FORCE with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8, 32'h800 + 32'(i), 1, 5'(20 + i), 32'hC0 + 32'(i));
      step();
    end
    drive(1, 8, 32'h8FF, 0, 0, 0);
    sawStall = 1'b0;
    for (int i = 0; i < 20 && !sawStall; i++) begin
      if (outStall) sawStall = 1'b1;
      else step();
    end
    check("reach FORCE", 32'(sawStall), 1);
    check("FORCE pending before reset", 32'(outPending), 3);
    #2 rst = 1'b0;
    #1;
    check("rst stall",   32'(outStall),     0);
    check("rst pending", 32'(outPending),   0);
    check("rst ready",   32'(outDbg_ready), 1);
    check("rst wr",      32'(outRegF_wr),   0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post rst%0d wr", i),    32'(outRegF_wr),  0);
      check($sformatf("post rst%0d grant", i), 32'(outGrantDbg), 0);
      check($sformatf("post rst%0d stall", i), 32'(outStall),    0);
      check($sformatf("post rst%0d pend", i),  32'(outPending),  0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
